// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: write-side front end for the 32x32 register file.
// Merges the primary writeback (never stalled) with a secondary producer
// queued through a small FIFO, drives the single RF write port from a
// registered stage, and exports pending-write flags for decode stalls.
// Optional feature macro: RF_WA_BYPASS_EN (secondary writes skip an empty
// FIFO and load the rf stage directly when the primary is idle).
module rf_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_we,
  input  logic [AW-1:0]            p_waddr,
  input  logic [DW-1:0]            p_wdata,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [AW-1:0]            s_waddr,
  input  logic [DW-1:0]            s_wdata,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            chk_addr1,
  input  logic [AW-1:0]            chk_addr2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     q_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic prim_req;
  logic s_keep;
  logic bypass;
  logic push;
  logic pop;
  logic hit1;
  logic hit2;

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];

  // Occupancy flags come from registered pointers only.
  assign q_count = wr_ptr - rd_ptr;
  assign q_full  = (q_count == CW'(DEPTH));
  assign q_empty = (wr_ptr == rd_ptr);

  // No path from s_valid; reset holds the producer off.
  assign s_ready = !q_full && !rst;

  // Request decode: writes to $0 are treated as no request at all.
  always_comb begin
    prim_req = p_we && (p_waddr != '0);
    s_keep   = s_valid && s_ready && (s_waddr != '0);
`ifdef RF_WA_BYPASS_EN
    bypass   = s_keep && q_empty && !prim_req;
`else
    bypass   = 1'b0;
`endif
    push     = s_keep && !bypass;
    pop      = !prim_req && !q_empty;
  end

  // FIFO pointers and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + CW'(1);
        ent_valid[wr_idx] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + CW'(1);
        ent_valid[rd_idx] <= 1'b0;
      end
    end
  end

  // FIFO payload storage; contents are qualified by ent_valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_idx] <= s_waddr;
      ent_data[wr_idx] <= s_wdata;
    end
  end

  // Registered RF write stage: primary first, then FIFO head, then bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (prim_req) begin
      rf_we    <= 1'b1;
      rf_waddr <= p_waddr;
      rf_wdata <= p_wdata;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= ent_addr[rd_idx];
      rf_wdata <= ent_data[rd_idx];
    end else if (bypass) begin
      rf_we    <= 1'b1;
      rf_waddr <= s_waddr;
      rf_wdata <= s_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Pending flags: match against queued entries and the not-yet-committed rf stage.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[PW'(i)] && (ent_addr[PW'(i)] == chk_addr1)) hit1 = 1'b1;
      if (ent_valid[PW'(i)] && (ent_addr[PW'(i)] == chk_addr2)) hit2 = 1'b1;
    end
    pend1 = (chk_addr1 != '0) && (hit1 || (rf_we && (rf_waddr == chk_addr1)));
    pend2 = (chk_addr2 != '0) && (hit2 || (rf_we && (rf_waddr == chk_addr2)));
  end

endmodule
